// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Round-robin arbiter and sequencer for a 4-to-1 mux datapath. Four
//   requesters (a, b, c, d) share one valid/ready output channel. A granted
//   requester keeps the channel until it sends its last beat, or until
//   MAX_BURST beats have transferred. The search start pointer then rotates
//   past the released requester. An idle bubble cycle always separates
//   consecutive bursts.
//
//   Ports
//     clk_i     clock, all state updates on the rising edge
//     rst_i     synchronous reset, active-high
//     req_i     req_i[i]: requester i has a beat available (0=a .. 3=d)
//     last_i    last_i[i]: current beat of requester i ends its burst
//     a_i..d_i  requester data
//     ready_i   downstream accepts the beat when valid_o & ready_i
//     gnt_o     one-hot grant, registered, zero when idle
//     sel_o     encoded select of the granted requester, registered
//     out_o     data of the selected requester (combinational from sel_o)
//     valid_o   beat on out_o is valid
//
//   state | meaning
//   IDLE  | no grant; pick the next requester round-robin from ptr
//   BUSY  | channel owned by sel; beats flow while req[sel] & ready
module mux4_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       req_i,
    input  logic [3:0]       last_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             ready_i,
    output logic [3:0]       gnt_o,
    output logic [1:0]       sel_o,
    output logic [WIDTH-1:0] out_o,
    output logic             valid_o
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             found;
    logic [1:0]       win;
    logic [1:0]       idx;
    logic             xfer;

    // Round-robin search: first set request bit starting at ptr, wrapping mod 4.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        idx   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign valid_o = (state_q == BUSY) && req_i[sel_q];
    assign xfer    = valid_o && ready_i;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BUSY;
                    sel_d   = win;
                    gnt_d   = 4'b0001 << win;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (xfer) begin
                    if (last_i[sel_q] || (cnt_q == CNT_LAST)) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        ptr_d   = sel_q + 2'd1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        out_o = a_i;
        case (sel_q)
            2'd0: out_o = a_i;
            2'd1: out_o = b_i;
            2'd2: out_o = c_i;
            2'd3: out_o = d_i;
            default: out_o = a_i;
        endcase
    end

    assign gnt_o = gnt_q;
    assign sel_o = sel_q;

endmodule
